// File: rtl/bpred_pkg.sv
// Shared branch-predictor types: 2-bit PHT counter and its next-state helper.
package bpred_pkg;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam pht_ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam pht_ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam pht_ctr_t CTR_ST  = 2'b11;  // strongly taken

  // satCounter2: 2-bit saturating up/down counter step
  function automatic pht_ctr_t sat_counter2(input pht_ctr_t cur, input logic taken);
    if (taken) begin
      return (cur == CTR_ST) ? CTR_ST : pht_ctr_t'(cur + 2'd1);
    end
    return (cur == CTR_SNT) ? CTR_SNT : pht_ctr_t'(cur - 2'd1);
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Index/counter update FIFO with two parallel youngest-match lookup ports.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int unsigned K     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [K-1:0]   push_idx,
  input  pht_ctr_t       push_state,
  input  logic           pop,
  output logic [K-1:0]   head_idx,
  output pht_ctr_t       head_state,
  output logic           empty,
  output logic           full,
  input  logic [K-1:0]   m0_idx,
  output logic           m0_hit,
  output pht_ctr_t       m0_state,
  input  logic [K-1:0]   m1_idx,
  output logic           m1_hit,
  output pht_ctr_t       m1_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [K-1:0]     idx_q [DEPTH];
  logic [K-1:0]     idx_d [DEPTH];
  pht_ctr_t         st_q  [DEPTH];
  pht_ctr_t         st_d  [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    slot;

  // Pointer, valid and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2**AW)
  always_comb begin
    idx_d  = idx_q;
    st_d   = st_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + AW'(1);
    end
    if (push) begin
      idx_d[tail_q] = push_idx;
      st_d[tail_q]  = push_state;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage; qualified by the valid bits so no reset needed
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    st_q  <= st_d;
  end

  assign head_idx   = idx_q[head_q];
  assign head_state = st_q[head_q];
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));

  // Youngest-match search: walk oldest to youngest so the last hit wins
  always_comb begin
    slot     = '0;
    m0_hit   = 1'b0;
    m0_state = CTR_SNT;
    m1_hit   = 1'b0;
    m1_state = CTR_SNT;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head_q + AW'(i);
      if (vld_q[slot] && (idx_q[slot] == m0_idx)) begin
        m0_hit   = 1'b1;
        m0_state = st_q[slot];
      end
      if (vld_q[slot] && (idx_q[slot] == m1_idx)) begin
        m1_hit   = 1'b1;
        m1_state = st_q[slot];
      end
    end
  end

endmodule

// File: rtl/bpred_pht_updater.sv
// PHT write-side owner: post-reset init sweep, then queued counter updates drained to the PHT.
module bpred_pht_updater
  import bpred_pkg::*;
#(
  parameter int unsigned K          = 10,
  parameter int unsigned DEPTH      = 4,
  parameter pht_ctr_t    INIT_STATE = CTR_WNT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          UpdValid,
  input  logic [K-1:0]  UpdIndex,
  input  pht_ctr_t      UpdOldState,
  input  logic          UpdTaken,
  output logic          UpdReady,
  input  logic [K-1:0]  LookupIndex,
  output logic          LookupHit,
  output pht_ctr_t      LookupState,
  input  logic          WrPortBusy,
  output logic          PHTWe,
  output logic [K-1:0]  PHTWa,
  output pht_ctr_t      PHTWd,
  output logic          InitDone
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [K-1:0]  init_cnt_q, init_cnt_d;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [K-1:0]  head_idx;
  pht_ctr_t      head_state;
  logic          base_hit;
  pht_ctr_t      base_state, base_ctr, new_ctr;

  bpred_upd_fifo #(
    .K     (K),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_idx   (UpdIndex),
    .push_state (new_ctr),
    .pop        (fifo_pop),
    .head_idx   (head_idx),
    .head_state (head_state),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .m0_idx     (UpdIndex),
    .m0_hit     (base_hit),
    .m0_state   (base_state),
    .m1_idx     (LookupIndex),
    .m1_hit     (LookupHit),
    .m1_state   (LookupState)
  );

  // New counter builds on the youngest queued value so back-to-back updates chain
  always_comb begin
    base_ctr = base_hit ? base_state : UpdOldState;
    new_ctr  = sat_counter2(base_ctr, UpdTaken);
  end

  // Init/run FSM and write-port mux
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    PHTWe      = 1'b0;
    PHTWa      = '0;
    PHTWd      = INIT_STATE;
    UpdReady   = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_INIT: begin
        PHTWe = ~WrPortBusy & ~reset;
        PHTWa = init_cnt_q;
        if (PHTWe) begin
          init_cnt_d = init_cnt_q + K'(1);
          if (init_cnt_q == '1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        UpdReady  = ~fifo_full;
        fifo_push = UpdValid & ~fifo_full;
        if (~fifo_empty && ~WrPortBusy) begin
          PHTWe    = 1'b1;
          PHTWa    = head_idx;
          PHTWd    = head_state;
          fifo_pop = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // FSM and sweep counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign InitDone = (state_q == ST_RUN);

endmodule

// File: tb/tb_bpred_pht_updater.sv
// Scoreboarded bench for bpred_pht_updater (K=4, DEPTH=4).
module tb_bpred_pht_updater;

  logic       clk;
  logic       reset;
  logic       UpdValid;
  logic [3:0] UpdIndex;
  logic [1:0] UpdOldState;
  logic       UpdTaken;
  logic       UpdReady;
  logic [3:0] LookupIndex;
  logic       LookupHit;
  logic [1:0] LookupState;
  logic       WrPortBusy;
  logic       PHTWe;
  logic [3:0] PHTWa;
  logic [1:0] PHTWd;
  logic       InitDone;

  int total = 0;
  int bad   = 0;
  logic [5:0] sbq [$];

  int t5_idx [5] = '{1, 2, 3, 4, 7};
  int t5_old [5] = '{0, 1, 2, 3, 1};
  int t5_tk  [5] = '{1, 0, 1, 0, 1};
  int t5_exp [5] = '{1, 0, 3, 2, 2};

  bpred_pht_updater #(
    .K          (4),
    .DEPTH      (4),
    .INIT_STATE (2'b01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .UpdValid    (UpdValid),
    .UpdIndex    (UpdIndex),
    .UpdOldState (UpdOldState),
    .UpdTaken    (UpdTaken),
    .UpdReady    (UpdReady),
    .LookupIndex (LookupIndex),
    .LookupHit   (LookupHit),
    .LookupState (LookupState),
    .WrPortBusy  (WrPortBusy),
    .PHTWe       (PHTWe),
    .PHTWa       (PHTWa),
    .PHTWd       (PHTWd),
    .InitDone    (InitDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input int old, input int tk);
    UpdValid    = 1'b1;
    UpdIndex    = 4'(idx);
    UpdOldState = 2'(old);
    UpdTaken    = 1'(tk);
  endtask

  task automatic push_sweep();
    for (int a = 0; a < 16; a++) sbq.push_back({4'(a), 2'b01});
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sbq.size() == 0) break;
      step();
    end
    chk("sb_drain_remaining", sbq.size(), 0);
  endtask

  // Pops the oldest expected write whenever the DUT writes the PHT
  task automatic sb_monitor();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (PHTWe === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pht_write_unexpected: got addr=%0d data=%0d expected none", PHTWa, PHTWd);
        end else begin
          e = sbq.pop_front();
          chk("pht_write_addr_data", {PHTWa, PHTWd}, e);
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    UpdValid    = 1'b0;
    UpdIndex    = '0;
    UpdOldState = '0;
    UpdTaken    = 1'b0;
    LookupIndex = '0;
    WrPortBusy  = 1'b0;
    fork
      sb_monitor();
    join_none

    // Reset values
    step();
    step();
    chk("rst_PHTWe", PHTWe, 0);
    chk("rst_PHTWa", PHTWa, 0);
    chk("rst_PHTWd", PHTWd, 1);
    chk("rst_UpdReady", UpdReady, 0);
    chk("rst_LookupHit", LookupHit, 0);
    chk("rst_LookupState", LookupState, 0);
    chk("rst_InitDone", InitDone, 0);

    // Full sweep, port free
    push_sweep();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_PHTWe", PHTWe, 1);
      chk("sweep_PHTWa", PHTWa, i);
      chk("sweep_InitDone", InitDone, 0);
      chk("sweep_UpdReady", UpdReady, 0);
      step();
    end
    chk("sweep_done_InitDone", InitDone, 1);
    chk("sweep_done_UpdReady", UpdReady, 1);
    chk("sweep_done_PHTWe", PHTWe, 0);

    // Sweep with the port busy in cycles 3-5
    reset = 1'b1;
    step();
    push_sweep();
    reset = 1'b0;
    for (int c = 0; c < 19; c++) begin
      WrPortBusy = (c >= 3 && c <= 5);
      #1;
      chk("busy_sweep_PHTWe", PHTWe, (c >= 3 && c <= 5) ? 0 : 1);
      chk("busy_sweep_PHTWa", PHTWa, (c <= 5) ? ((c < 3) ? c : 3) : c - 3);
      chk("busy_sweep_InitDone", InitDone, 0);
      step();
    end
    WrPortBusy = 1'b0;
    chk("busy_sweep_done", InitDone, 1);
    wait_drain(4);

    // Saturation at both ends, plus one-cycle enqueue latency
    drive(5, 3, 1);
    #1;
    chk("sat_UpdReady", UpdReady, 1);
    chk("sat_latency_PHTWe", PHTWe, 0);
    sbq.push_back({4'd5, 2'b11});
    step();
    drive(6, 0, 0);
    #1;
    chk("sat_first_write_we", PHTWe, 1);
    chk("sat_first_write_wa", PHTWa, 5);
    sbq.push_back({4'd6, 2'b00});
    step();
    UpdValid = 1'b0;
    wait_drain(10);

    // Chained updates to one index while stalled, lookup forwarding
    WrPortBusy  = 1'b1;
    LookupIndex = 4'd9;
    #1;
    chk("chain_lookup_before", LookupHit, 0);
    for (int i = 0; i < 3; i++) begin
      drive(9, 0, 1);
      sbq.push_back({4'd9, 2'(i + 1)});
      step();
      chk("chain_lookup_hit", LookupHit, 1);
      chk("chain_lookup_state", LookupState, i + 1);
    end
    UpdValid = 1'b0;
    chk("chain_UpdReady", UpdReady, 1);
    LookupIndex = 4'd5;
    #1;
    chk("chain_lookup_other", LookupHit, 0);
    LookupIndex = 4'd9;
    WrPortBusy  = 1'b0;
    wait_drain(10);
    #1;
    chk("chain_lookup_after_drain", LookupHit, 0);

    // Fill to DEPTH under stall; fifth update held until a drain frees a slot
    WrPortBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(t5_idx[i], t5_old[i], t5_tk[i]);
      #1;
      chk("fill_UpdReady", UpdReady, 1);
      sbq.push_back({4'(t5_idx[i]), 2'(t5_exp[i])});
      step();
    end
    drive(t5_idx[4], t5_old[4], t5_tk[4]);
    #1;
    chk("full_UpdReady", UpdReady, 0);
    step();
    chk("full_hold_UpdReady", UpdReady, 0);
    WrPortBusy = 1'b0;
    #1;
    chk("full_drain_UpdReady", UpdReady, 0);
    chk("full_drain_PHTWe", PHTWe, 1);
    step();
    chk("after_drain_UpdReady", UpdReady, 1);
    sbq.push_back({4'(t5_idx[4]), 2'(t5_exp[4])});
    step();
    UpdValid = 1'b0;
    wait_drain(20);

    // Reset while two entries are queued
    WrPortBusy = 1'b1;
    drive(10, 1, 1);
    step();
    drive(11, 2, 0);
    step();
    UpdValid    = 1'b0;
    LookupIndex = 4'd11;
    #1;
    chk("mid_lookup_hit", LookupHit, 1);
    chk("mid_lookup_state", LookupState, 1);
    LookupIndex = 4'd10;
    #1;
    chk("mid_lookup_state_10", LookupState, 2);
    LookupIndex = 4'd11;
    WrPortBusy  = 1'b0;
    sbq.push_back({4'd10, 2'b10});
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_PHTWe", PHTWe, 0);
    chk("midrst_LookupHit", LookupHit, 0);
    chk("midrst_UpdReady", UpdReady, 0);
    chk("midrst_InitDone", InitDone, 0);
    chk("midrst_PHTWa", PHTWa, 0);
    push_sweep();
    step();
    reset = 1'b0;
    #1;
    chk("restart_PHTWe", PHTWe, 1);
    chk("restart_PHTWa", PHTWa, 0);
    wait_drain(40);
    #1;
    chk("restart_InitDone", InitDone, 1);
    chk("restart_LookupHit", LookupHit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpred_pht_updater.md
Name: bpred_pht_updater

Overview:
- Write-side companion to the global-history direction predictor.
- Owns the pattern history table (PHT) write port:
  - after reset, sweeps every PHT entry to a known initial counter state;
  - then accepts resolved branch outcomes, computes the updated 2-bit saturating counter, and queues the writes in a small FIFO;
  - drains the FIFO into the PHT when the write port is free.
- Provides a lookup so the fetch-side reader can forward queued, not-yet-written counters.

Parameters:
- k, 10: PHT index width; the PHT has 2**k entries.
- DEPTH, 4: update FIFO entries; power of two, at least 2.
- INIT_STATE, 2'b01: counter value written to every entry during the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- UpdValid  in  1  resolved branch update offered
- UpdIndex  in  k  PHT index of resolved branch
- UpdOldState  in  2  counter value used when the branch was predicted
- UpdTaken  in  1  resolved direction
- UpdReady  out  1  update accepted this cycle when UpdValid & UpdReady
- LookupIndex  in  k  index being read by fetch
- LookupHit  out  1  a queued entry matches LookupIndex
- LookupState  out  2  counter of the youngest matching queued entry
- WrPortBusy  in  1  PHT write port unavailable this cycle
- PHTWe  out  1  PHT write enable
- PHTWa  out  k  PHT write address
- PHTWd  out  2  PHT write data
- InitDone  out  1  init sweep complete

Behaviour:
- Reset: asynchronous, active-high. It clears the FSM to INIT, the init counter to 0, FIFO head, tail and count to 0, and all entry valid bits.
- Output values during reset:
  - PHTWe=0, PHTWa=0, PHTWd=INIT_STATE;
  - UpdReady=0, LookupHit=0, LookupState=0, InitDone=0.
- FSM states are INIT and RUN.
- INIT:
  - PHTWe = ~WrPortBusy; PHTWa = init counter; PHTWd = INIT_STATE.
  - The init counter increments only on cycles where PHTWe=1.
  - When a write occurs at address 2**k-1, go to RUN on the next edge.
  - UpdReady=0. UpdValid is ignored.
  - A full sweep takes exactly 2**k cycles when WrPortBusy stays 0.
- RUN:
  - InitDone=1 (registered, from the FSM state).
  - UpdReady = (count < DEPTH). A dequeue in the same cycle does not raise UpdReady.
- Enqueue, on UpdValid & UpdReady:
  - Base counter = state of the youngest valid FIFO entry whose index equals UpdIndex; if no entry matches, base = UpdOldState.
  - New counter: taken gives min(base+1, 3); not-taken gives max(base-1, 0).
  - Write {UpdIndex, new counter} at the tail. Tail wraps modulo DEPTH.
  - Matching entries are never merged; each update occupies its own entry.
- Drain, combinational from registered state:
  - PHTWe = (count != 0) & ~WrPortBusy & RUN.
  - PHTWa and PHTWd come from the head entry.
  - When PHTWe=1, the head is invalidated and advances on the same edge; head wraps modulo DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Enqueue latency: an accepted update can reach PHTWe on the next cycle at the earliest.
- Lookup:
  - Purely combinational over valid entries.
  - With several matches, the youngest entry (closest to tail) wins.
  - An update enqueued in cycle N is visible to lookup from cycle N+1.
  - An entry dequeued in cycle N is not visible from cycle N+1, because the PHT holds it by then.
- WrPortBusy held high: the FIFO stalls. The FIFO fills to DEPTH, then UpdReady drops. No update is lost or reordered.
- Reset mid-sweep or mid-drain: queued updates are discarded and the sweep restarts from address 0.

Decomposition:
- Shared package (bpred): PHT counter typedef (2-bit) and the counter encodings for strongly not-taken, weakly not-taken, weakly taken and strongly taken.
- Saturating counter next-state function: reuse the existing satCounter2 instance rather than duplicating the logic.
- One sub-module, bpred_upd_fifo:
  - DEPTH-entry index/state FIFO with a parallel match port returning the youngest hit;
  - used twice: once for the enqueue base-counter lookup and once for LookupIndex.
- Top level: init/run FSM plus write-port mux.

Test Plan (k=4, DEPTH=4):
- Reset release, WrPortBusy=0 -> PHTWe=1 for 16 consecutive cycles, PHTWa 0..15, PHTWd=01; InitDone=1 and UpdReady=1 in cycle 17.
- Init with WrPortBusy high in cycles 3-5 -> PHTWa holds 3 for those cycles; sweep finishes in 19 cycles with no address skipped.
- RUN, enqueue idx=5 old=11 taken=1 and idx=6 old=00 taken=0 -> PHT writes (5,11) then (6,00); saturation holds at both ends.
- WrPortBusy=1, three taken updates to idx=9 with old=00 each -> queued states 01, 10, 11; LookupIndex=9 gives LookupHit=1, LookupState=11; release WrPortBusy -> writes 01, 10, 11 in order.
- WrPortBusy=1, five valid updates -> UpdReady=0 after the 4th is accepted; 5th held until the first drain; all writes in order.
- Assert reset while 2 entries are queued -> PHTWe drops immediately, LookupHit=0, sweep restarts at PHTWa=0.
